// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing four seven-segment digits between requesters A and B.
// The owner keeps the display for at least HOLD_CYCLES cycles. Its 16-bit value is
// captured and decoded into active-low glyphs, with optional leading-zero blanking.
module hex_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter bit          BLANK_IDLE  = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    input  logic        lz_en,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [0:6]  HEX3,
    output logic [0:6]  HEX2,
    output logic [0:6]  HEX1,
    output logic [0:6]  HEX0
);

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t      state;
    logic [15:0] shown;
    logic [15:0] cnt;
    logic        last_b;

    logic        show;
    logic        z3, z2, z1;

    function automatic logic [0:6] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Ownership FSM: grants, hold counter, shown-value capture and round-robin history
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            shown  <= '0;
            cnt    <= '0;
            last_b <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_a && (!req_b || last_b)) begin
                        state  <= OWN_A;
                        gnt_a  <= 1'b1;
                        gnt_b  <= 1'b0;
                        shown  <= data_a;
                        cnt    <= HOLD_LOAD;
                        last_b <= 1'b0;
                    end else if (req_b) begin
                        state  <= OWN_B;
                        gnt_a  <= 1'b0;
                        gnt_b  <= 1'b1;
                        shown  <= data_b;
                        cnt    <= HOLD_LOAD;
                        last_b <= 1'b1;
                    end
                end
                OWN_A: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                        if (req_a) shown <= data_a;
                    end else if (req_b) begin
                        state  <= OWN_B;
                        gnt_a  <= 1'b0;
                        gnt_b  <= 1'b1;
                        shown  <= data_b;
                        cnt    <= HOLD_LOAD;
                        last_b <= 1'b1;
                    end else if (!req_a) begin
                        state <= IDLE;
                        gnt_a <= 1'b0;
                    end else begin
                        shown <= data_a;
                    end
                end
                OWN_B: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                        if (req_b) shown <= data_b;
                    end else if (req_a) begin
                        state  <= OWN_A;
                        gnt_a  <= 1'b1;
                        gnt_b  <= 1'b0;
                        shown  <= data_a;
                        cnt    <= HOLD_LOAD;
                        last_b <= 1'b0;
                    end else if (!req_b) begin
                        state <= IDLE;
                        gnt_b <= 1'b0;
                    end else begin
                        shown <= data_b;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_a <= 1'b0;
                    gnt_b <= 1'b0;
                end
            endcase
        end
    end

    // Combinational glyph decode with idle and leading-zero blanking
    always_comb begin
        show = (state != IDLE) || !BLANK_IDLE;
        z3   = (shown[15:12] == 4'h0);
        z2   = z3 && (shown[11:8] == 4'h0);
        z1   = z2 && (shown[7:4] == 4'h0);
        HEX3 = (!show || (lz_en && z3)) ? '1 : glyph(shown[15:12]);
        HEX2 = (!show || (lz_en && z2)) ? '1 : glyph(shown[11:8]);
        HEX1 = (!show || (lz_en && z1)) ? '1 : glyph(shown[7:4]);
        HEX0 = !show ? '1 : glyph(shown[3:0]);
    end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench: two DUT instances (HOLD 4 / blank idle, HOLD 1 / keep idle)
// share stimulus; a reference model pushes expected outputs, a monitor pops/compares.
module tb_hex_display_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, lz_en = 1'b0;
    logic [15:0] data_a = '0, data_b = '0;

    logic        ga0, gb0, ga1, gb1;
    logic [0:6]  h3_0, h2_0, h1_0, h0_0;
    logic [0:6]  h3_1, h2_1, h1_1, h0_1;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    hex_display_arbiter #(.HOLD_CYCLES(4), .BLANK_IDLE(1'b1)) dut0 (
        .Clock(clk), .Reset(rst), .req_a(req_a), .data_a(data_a),
        .req_b(req_b), .data_b(data_b), .lz_en(lz_en),
        .gnt_a(ga0), .gnt_b(gb0), .HEX3(h3_0), .HEX2(h2_0), .HEX1(h1_0), .HEX0(h0_0)
    );

    hex_display_arbiter #(.HOLD_CYCLES(1), .BLANK_IDLE(1'b0)) dut1 (
        .Clock(clk), .Reset(rst), .req_a(req_a), .data_a(data_a),
        .req_b(req_b), .data_b(data_b), .lz_en(lz_en),
        .gnt_a(ga1), .gnt_b(gb1), .HEX3(h3_1), .HEX2(h2_1), .HEX1(h1_1), .HEX0(h0_1)
    );

    // Reference model: owner 0 = none, 1 = A, 2 = B
    int          m_owner [2];
    int          m_hold  [2];
    int          m_last  [2];
    logic [15:0] m_shown [2];
    int          p_hold  [2] = '{4, 1};
    int          p_blank [2] = '{1, 0};
    logic [6:0]  glyphs  [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    typedef struct {
        string       tag;
        logic [29:0] v [2];
    } exp_t;

    exp_t sb[$];
    bit   stim_done = 1'b0;

    task automatic model_grant(input int i, input int who, input logic [15:0] da, input logic [15:0] db);
        m_owner[i] = who;
        m_shown[i] = (who == 1) ? da : db;
        m_hold[i]  = p_hold[i] - 1;
        m_last[i]  = who;
    endtask

    task automatic model_step(input int i, input logic r, input logic ra, input logic [15:0] da,
                              input logic rb, input logic [15:0] db);
        int mine, other;
        if (r) begin
            m_owner[i] = 0; m_hold[i] = 0; m_last[i] = 2; m_shown[i] = 16'h0000;
        end else if (m_owner[i] == 0) begin
            if (ra && rb)  model_grant(i, (m_last[i] == 1) ? 2 : 1, da, db);
            else if (ra)   model_grant(i, 1, da, db);
            else if (rb)   model_grant(i, 2, da, db);
        end else begin
            mine  = (m_owner[i] == 1) ? int'(ra) : int'(rb);
            other = (m_owner[i] == 1) ? int'(rb) : int'(ra);
            if (m_hold[i] > 0) begin
                m_hold[i] = m_hold[i] - 1;
                if (mine != 0) m_shown[i] = (m_owner[i] == 1) ? da : db;
            end else if (other != 0) begin
                model_grant(i, 3 - m_owner[i], da, db);
            end else if (mine == 0) begin
                m_owner[i] = 0;
            end else begin
                m_shown[i] = (m_owner[i] == 1) ? da : db;
            end
        end
    endtask

    function automatic logic [29:0] model_out(input int i, input logic lz);
        logic [6:0] d [4];
        logic [3:0] nib;
        bit         leading = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            nib = m_shown[i][k*4 +: 4];
            if (m_owner[i] == 0 && p_blank[i] == 1) d[k] = 7'b1111111;
            else if (lz && leading && nib == 4'h0 && k != 0) d[k] = 7'b1111111;
            else d[k] = glyphs[nib];
            if (nib != 4'h0) leading = 1'b0;
        end
        return {(m_owner[i] == 1), (m_owner[i] == 2), d[3], d[2], d[1], d[0]};
    endfunction

    task automatic step(input logic r, input logic ra, input logic [15:0] da,
                        input logic rb, input logic [15:0] db, input logic lz, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; req_a = ra; data_a = da; req_b = rb; data_b = db; lz_en = lz;
        e.tag = tag;
        for (int i = 0; i < 2; i++) begin
            model_step(i, r, ra, da, rb, db);
            e.v[i] = model_out(i, lz);
        end
        sb.push_back(e);
    endtask

    // Monitor: one expected entry per clock edge, sampled 2 time units after the edge
    initial begin
        exp_t        e;
        logic [29:0] act [2];
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act[0] = {ga0, gb0, h3_0, h2_0, h1_0, h0_0};
                act[1] = {ga1, gb1, h3_1, h2_1, h1_1, h0_1};
                for (int i = 0; i < 2; i++) begin
                    vectors++;
                    if (act[i] !== e.v[i]) begin
                        errors++;
                        $display("FAIL %s dut%0d: got gnt=%b%b hex=%b_%b_%b_%b want gnt=%b%b hex=%b_%b_%b_%b",
                                 e.tag, i, act[i][29], act[i][28], act[i][27:21], act[i][20:14],
                                 act[i][13:7], act[i][6:0], e.v[i][29], e.v[i][28], e.v[i][27:21],
                                 e.v[i][20:14], e.v[i][13:7], e.v[i][6:0]);
                    end
                end
            end
        end
    end

    initial begin
        logic        r, ra, rb, lz;
        logic [15:0] da, db;

        // 1: single request from A
        step(1, 0, 16'h0, 0, 16'h0, 0, "reset");
        step(0, 1, 16'h12AF, 0, 16'h0, 0, "t1_grant_a");
        step(0, 1, 16'h12AF, 0, 16'h0, 0, "t1_hold_a");

        // 2: tie after reset, B keeps requesting
        step(1, 0, 16'h0, 0, 16'h0, 0, "reset");
        for (int k = 0; k < 7; k++) step(0, 1, 16'hA5A5, 1, 16'h5A5A, 0, "t2_tie_switch");

        // 3: A drops its request after one cycle
        step(1, 0, 16'h0, 0, 16'h0, 0, "reset");
        step(0, 1, 16'h3C3C, 0, 16'h0, 0, "t3_grant");
        for (int k = 0; k < 5; k++) step(0, 0, 16'hFFFF, 0, 16'h0, 0, "t3_freeze_idle");

        // 4 and 5: leading-zero blanking
        step(1, 0, 16'h0, 0, 16'h0, 1, "reset");
        step(0, 1, 16'h0007, 0, 16'h0, 1, "t4_lz_0007");
        step(0, 1, 16'h0000, 0, 16'h0, 1, "t5_lz_0000");
        step(0, 1, 16'h0040, 0, 16'h0, 1, "lz_0040");
        step(0, 1, 16'h0300, 0, 16'h0, 1, "lz_0300");

        // 6: B live tracking, reset mid-hold, then a tie
        step(1, 0, 16'h0, 0, 16'h0, 0, "reset");
        step(0, 0, 16'h0, 1, 16'h0001, 0, "t6_track1");
        step(0, 0, 16'h0, 1, 16'h0002, 0, "t6_track2");
        step(0, 0, 16'h0, 1, 16'h0003, 0, "t6_track3");
        step(1, 0, 16'h0, 1, 16'h0004, 0, "t6_reset_mid");
        step(0, 1, 16'h1111, 1, 16'h2222, 0, "t6_tie_after_reset");
        step(0, 1, 16'h1111, 1, 16'h2222, 0, "t6_tie_hold");

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(0, 63) == 0);
            ra = ($urandom_range(0, 2) != 0);
            rb = ($urandom_range(0, 2) != 0);
            lz = 1'($urandom_range(0, 1));
            da = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            db = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            step(r, ra, da, rb, db, lz, "random");
        end

        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
